dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port, word-organised data memory. Port 0 is the core load/store path and port 1 is the debug/DMA path. Byte-enabled stores are converted into a read-modify-write sequence, because the memory writes whole words only. Only one access is in flight at a time; arbitration is round-robin.

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Two-port round-robin arbiter and access sequencer for a single-port,
// word-organised data memory with a combinational read path. Port 0 is the
// core load/store path, port 1 the debug/DMA path. One access is in flight
// at a time. The memory writes whole words only, so partial byte-enable
// stores are sequenced as read (ACCESS) followed by write (RMW_WR).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake (ready is combinational)
//   reqN_addr/we/be/wdata      byte address, store flag, byte enables, data
//   respN_valid/rdata/err      one-cycle response pulse, load data, range error
//   mem_addr/re/we/wdata       word-aligned memory command
//   mem_rdata                  memory read data (same-cycle)
//   conflict_cnt               saturating count of IDLE cycles with both ports valid
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    input  logic [3:0]        req0_be,
    input  logic [31:0]       req0_wdata,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [3:0]        req1_be,
    input  logic [31:0]       req1_wdata,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              resp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RMW_WR = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_reg;
    logic              last_grant_reg;
    logic [15:0]       conflict_cnt_reg;
    logic              port_reg;
    logic [ADDR_W-3:0] word_reg;      // latched word index (byte offset dropped)
    logic              we_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       merge_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic              is_idle;
    logic              both_valid;
    logic              any_valid;
    logic              grant;         // winning port id in IDLE
    logic              out_of_range;
    logic              be_full;
    logic              be_partial;
    logic [31:0]       merge_next;

    // Byte-offset bits of the request addresses carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req0_addr[1:0], req1_addr[1:0]};

    // ------------------------------------------------------------------
    // Arbitration: a lone valid port wins; on a tie the port that did not
    // win last time is chosen.
    // ------------------------------------------------------------------
    assign is_idle    = (state_reg == S_IDLE);
    assign both_valid = req0_valid & req1_valid;
    assign any_valid  = req0_valid | req1_valid;
    assign grant      = both_valid ? ~last_grant_reg : req1_valid;

    // ready is gated by rst_n so it reads 0 while reset is held.
    assign req0_ready = rst_n & is_idle & req0_valid & ~grant;
    assign req1_ready = rst_n & is_idle & req1_valid &  grant;

    // ------------------------------------------------------------------
    // Access decode on the latched request
    // ------------------------------------------------------------------
    assign out_of_range = ({2'b00, word_reg} >= ADDR_W'(MEM_WORDS));
    assign be_full      = (be_reg == 4'hF);
    assign be_partial   = (be_reg != 4'h0) && !be_full;

    // Per-lane merge of store data over the word read in ACCESS.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merge_next[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                                      : mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Memory strobes are decoded from state, so an asynchronous reset drops
    // them immediately and an interrupted read-modify-write never writes.
    assign mem_addr  = {word_reg, 2'b00};
    assign mem_re    = (state_reg == S_ACCESS) && !out_of_range && (!we_reg || be_partial);
    assign mem_we    = ((state_reg == S_ACCESS) && !out_of_range && we_reg && be_full)
                     || (state_reg == S_RMW_WR);
    assign mem_wdata = (state_reg == S_RMW_WR) ? merge_reg : wdata_reg;

    // Responses are forced to 0 outside the RESP pulse and on the idle port.
    assign resp0_valid = (state_reg == S_RESP) && (port_reg == 1'b0);
    assign resp1_valid = (state_reg == S_RESP) && (port_reg == 1'b1);
    assign resp0_rdata = resp0_valid ? rdata_reg : 32'h0;
    assign resp1_rdata = resp1_valid ? rdata_reg : 32'h0;
    assign resp0_err   = resp0_valid & err_reg;
    assign resp1_err   = resp1_valid & err_reg;

    assign conflict_cnt = conflict_cnt_reg;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            last_grant_reg   <= 1'b1;
            conflict_cnt_reg <= 16'h0;
            port_reg         <= 1'b0;
            word_reg         <= '0;
            we_reg           <= 1'b0;
            be_reg           <= 4'h0;
            wdata_reg        <= 32'h0;
            merge_reg        <= 32'h0;
            rdata_reg        <= 32'h0;
            err_reg          <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A valid port always holds the grant, so any valid
                    // request is a handshake this cycle.
                    if (any_valid) begin
                        if (both_valid && (conflict_cnt_reg != 16'hFFFF)) begin
                            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
                        end
                        port_reg       <= grant;
                        last_grant_reg <= grant;
                        word_reg       <= grant ? req1_addr[ADDR_W-1:2] : req0_addr[ADDR_W-1:2];
                        we_reg         <= grant ? req1_we    : req0_we;
                        be_reg         <= grant ? req1_be    : req0_be;
                        wdata_reg      <= grant ? req1_wdata : req0_wdata;
                        rdata_reg      <= 32'h0;
                        err_reg        <= 1'b0;
                        state_reg      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (out_of_range) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_RESP;
                    end else if (!we_reg) begin
                        rdata_reg <= mem_rdata;
                        state_reg <= S_RESP;
                    end else if (be_partial) begin
                        merge_reg <= merge_next;
                        state_reg <= S_RMW_WR;
                    end else begin
                        state_reg <= S_RESP;
                    end
                end
                S_RMW_WR: begin
                    state_reg <= S_RESP;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Directed and random stimulus for dmem_arbiter. A word memory with
// combinational read sits behind the DUT; an expected memory image and
// per-request expectations (latency, strobes, data, error, arbitration
// winner, conflict count) are computed from the access rules.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_be;
    logic        resp0_valid, resp0_err;
    logic [31:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_be;
    logic        resp1_valid, resp1_err;
    logic [31:0] resp1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic [15:0] conflict_cnt;

    dmem_arbiter #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_be(req0_be), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_be(req1_be), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory behind the DUT ----------------
    logic [31:0] tb_mem [0:1023];
    logic        init_done = 1'b0;
    int          we_pulses = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h9E3779B9 * 32'(i));
    endfunction

    assign mem_rdata = (mem_addr[31:12] == 20'h0) ? tb_mem[mem_addr[11:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (mem_we && (mem_addr[31:12] == 20'h0)) begin
            tb_mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_we) we_pulses <= we_pulses + 1;
    end

    // ---------------- reference state ----------------
    logic [31:0] ref_mem [0:1023];
    logic        exp_last;
    int          exp_conf;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic get_rvalid(input int p);
        return (p == 0) ? resp0_valid : resp1_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? resp0_rdata : resp1_rdata;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? resp0_err : resp1_err;
    endfunction

    task automatic set_req(input int p, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd, input logic v);
        if (p == 0) begin
            req0_addr = a; req0_we = we; req0_be = be; req0_wdata = wd; req0_valid = v;
        end else begin
            req1_addr = a; req1_we = we; req1_be = be; req1_wdata = wd; req1_valid = v;
        end
    endtask

    // One request on port p, checked cycle by cycle from handshake to IDLE.
    // Entered and left in an IDLE cycle, after the rising edge.
    task automatic xact(input int p, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd);
        logic        oor, full, part;
        logic [9:0]  idx;
        logic [31:0] old_w, new_w, exp_rd;
        int          exp_we, w0;
        oor   = (a[31:12] != 20'h0);
        idx   = a[11:2];
        old_w = ref_mem[idx];
        for (int n = 0; n < 4; n++) new_w[8*n +: 8] = be[n] ? wd[8*n +: 8] : old_w[8*n +: 8];
        full   = (be == 4'hF);
        part   = we && !oor && (be != 4'h0) && !full;
        exp_rd = (!we && !oor) ? old_w : 32'h0;
        exp_we = (we && !oor && (be != 4'h0)) ? 1 : 0;

        set_req(p, a, we, be, wd, 1'b1);
        #1;
        chk("ready_winner", get_ready(p), 1'b1);
        chk("ready_other", get_ready(1 - p), 1'b0);
        chk("idle_re", mem_re, 1'b0);
        chk("idle_we", mem_we, 1'b0);
        w0 = we_pulses;

        @(posedge clk); #1;
        set_req(p, a, we, be, wd, 1'b0);
        #1;
        chk("access_re", mem_re, !oor && (!we || part));
        chk("access_we", mem_we, !oor && we && full);
        if (!oor && (!we || (be != 4'h0))) chk("access_addr", mem_addr, {a[31:2], 2'b00});
        if (!oor && we && full) chk("access_wdata", mem_wdata, wd);
        chk("access_rvalid", get_rvalid(p), 1'b0);

        if (part) begin
            @(posedge clk); #2;
            chk("rmw_we", mem_we, 1'b1);
            chk("rmw_re", mem_re, 1'b0);
            chk("rmw_addr", mem_addr, {a[31:2], 2'b00});
            chk("rmw_wdata", mem_wdata, new_w);
            chk("rmw_rvalid", get_rvalid(p), 1'b0);
        end

        @(posedge clk); #2;
        chk("resp_valid", get_rvalid(p), 1'b1);
        chk("resp_rdata", get_rdata(p), exp_rd);
        chk("resp_err", get_err(p), oor);
        chk("resp_other_valid", get_rvalid(1 - p), 1'b0);
        chk("resp_other_rdata", get_rdata(1 - p), 32'h0);
        chk("resp_other_err", get_err(1 - p), 1'b0);
        chk("resp_re", mem_re, 1'b0);
        chk("resp_we", mem_we, 1'b0);

        @(posedge clk); #2;
        chk("post_valid", get_rvalid(p), 1'b0);
        chk("post_rdata", get_rdata(p), 32'h0);
        chk("we_pulses", 32'(we_pulses - w0), 32'(exp_we));
        if (we && !oor) ref_mem[idx] = new_w;
        if (!oor) chk("mem_word", tb_mem[idx], ref_mem[idx]);
        exp_last = p[0];
        $display("xact port=%0d addr=%h we=%0d be=%h wdata=%h exp_rdata=%h exp_err=%0d",
                 p, a, we, be, wd, exp_rd, oor);
    endtask

    // Both ports request at once; the port that lost last time wins first.
    task automatic tie(input logic [31:0] a0, input logic we0, input logic [3:0] be0, input logic [31:0] wd0,
                       input logic [31:0] a1, input logic we1, input logic [3:0] be1, input logic [31:0] wd1);
        int w;
        w = exp_last ? 0 : 1;
        set_req(0, a0, we0, be0, wd0, 1'b1);
        set_req(1, a1, we1, be1, wd1, 1'b1);
        #1;
        chk("tie_ready_winner", get_ready(w), 1'b1);
        chk("tie_ready_loser", get_ready(1 - w), 1'b0);
        if (exp_conf < 16'hFFFF) exp_conf++;
        if (w == 0) begin
            xact(0, a0, we0, be0, wd0);
            xact(1, a1, we1, be1, wd1);
        end else begin
            xact(1, a1, we1, be1, wd1);
            xact(0, a0, we0, be0, wd0);
        end
        chk("tie_conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));
    endtask

    task automatic rand_op(output logic [31:0] a, output logic we,
                           output logic [3:0] be, output logic [31:0] wd);
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0)      a = 32'($urandom_range(1024, 1100)) * 32'd4;
        else if (k == 1) a = $urandom | 32'h8000_0000;
        else             a = 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
        we = 1'($urandom_range(0, 1));
        k  = int'($urandom_range(0, 3));
        if (k == 0)      be = 4'hF;
        else if (k == 1) be = 4'h0;
        else             be = 4'($urandom_range(1, 14));
        wd = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          gport [0:15];
        int          busy;
        int          w;
        logic [31:0] a0, a1, wd0, wd1;
        logic        we0, we1;
        logic [3:0]  be0, be1;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        exp_last = 1'b1;
        exp_conf = 0;

        // Reset held with a pending request: every output stays 0.
        rst_n = 1'b0;
        set_req(0, 32'h10, 1'b0, 4'hF, 32'h0, 1'b1);
        set_req(1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        @(posedge clk); #2;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_resp0", resp0_valid, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_conflict", 32'(conflict_cnt), 32'h0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        // Directed accesses.
        xact(0, 32'h10, 1'b0, 4'hF, 32'h0);
        xact(1, 32'h20, 1'b1, 4'hF, 32'h12345678);
        xact(0, 32'h20, 1'b0, 4'hF, 32'h0);
        xact(1, 32'h20, 1'b1, 4'hF, 32'hAABBCCDD);
        xact(0, 32'h20, 1'b1, 4'b0101, 32'h11223344);
        chk("rmw_result", tb_mem[8], 32'hAA22CC44);
        xact(0, 32'h1000, 1'b0, 4'hF, 32'h0);
        xact(1, 32'h1004, 1'b1, 4'b0011, 32'hCAFEF00D);
        xact(0, 32'h24, 1'b1, 4'h0, 32'h55555555);

        // Reset asserted during RMW_WR: write is abandoned.
        set_req(0, 32'h20, 1'b1, 4'b0011, 32'h99887766, 1'b1);
        #1;
        chk("rmwrst_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("rmwrst_we_before", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rmwrst_we_async", mem_we, 1'b0);
        chk("rmwrst_re", mem_re, 1'b0);
        chk("rmwrst_resp0", resp0_valid, 1'b0);
        @(posedge clk); #2;
        chk("rmwrst_word_kept", tb_mem[8], ref_mem[8]);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            chk("rmwrst_no_resp0", resp0_valid, 1'b0);
            chk("rmwrst_no_resp1", resp1_valid, 1'b0);
        end
        exp_last = 1'b1;
        exp_conf = 0;
        $display("xact reset during RMW_WR port=0 addr=00000020 dropped");

        // Both ports continuously loading for 12 cycles.
        for (int i = 0; i < 16; i++) gport[i] = -1;
        busy = 0;
        set_req(0, 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
        set_req(1, 32'h44, 1'b0, 4'hF, 32'h0, 1'b1);
        #1;
        for (int c = 0; c < 12; c++) begin
            if (busy == 0) begin
                w = exp_last ? 0 : 1;
                chk("cont_ready_winner", get_ready(w), 1'b1);
                chk("cont_ready_loser", get_ready(1 - w), 1'b0);
                exp_last = w[0];
                exp_conf++;
                gport[c] = w;
                busy = 2;
                $display("xact contention cycle=%0d grant port=%0d", c, w);
            end else begin
                chk("cont_ready0_busy", req0_ready, 1'b0);
                chk("cont_ready1_busy", req1_ready, 1'b0);
                busy--;
            end
            if (c >= 2 && gport[c-2] >= 0) begin
                chk("cont_resp_valid", get_rvalid(gport[c-2]), 1'b1);
                chk("cont_resp_rdata", get_rdata(gport[c-2]), ref_mem[16 + gport[c-2]]);
                chk("cont_resp_other", get_rvalid(1 - gport[c-2]), 1'b0);
            end else begin
                chk("cont_no_resp0", resp0_valid, 1'b0);
                chk("cont_no_resp1", resp1_valid, 1'b0);
            end
            @(posedge clk); #2;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_conflict_cnt", 32'(conflict_cnt), 32'd4);

        // Random single requests and ties.
        for (int it = 0; it < 40; it++) begin
            rand_op(a0, we0, be0, wd0);
            if ($urandom_range(0, 3) == 0) begin
                rand_op(a1, we1, be1, wd1);
                tie(a0, we0, be0, wd0, a1, we1, be1, wd1);
            end else begin
                xact(int'($urandom_range(0, 1)), a0, we0, be0, wd0);
            end
        end
        chk("final_conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
